// File: rtl/fpga_conf_ctrl.sv
// fpga_conf_ctrl: SPI-fed configuration controller with guarded major-mode switching
//   pck0       in   sole clock
//   nrst       in   async active-low reset, deassertion synchronized to pck0
//   spck/ncs/mosi in SPI from the ARM (asynchronous)
//   miso       out  readback {4'b1001, 3'b000, busy, conf_word}, MSB first
//   conf_word  out  active configuration, [7:5] = major mode
//   divisor    out  active LF clock divisor
//   busy       out  major-mode switch in progress
//   cmd_strobe out  one-cycle pulse per valid 16-bit frame
//   frame_err  out  one-cycle pulse per frame with wrong bit count
module fpga_conf_ctrl #(
    parameter int          GUARD_CYCLES = 64,
    parameter logic [7:0]  DIV_RESET    = 8'd95
) (
    input  logic       pck0,
    input  logic       nrst,
    input  logic       spck,
    input  logic       ncs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       frame_err
);
    typedef enum logic {IDLE, QUIESCE} state_e;

    localparam logic [7:0] OFF_CONF = 8'hE0;
    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES - 1);

    logic [1:0]  rst_q;
    logic        rst_n;
    logic [2:0]  spck_q, ncs_q;
    logic [1:0]  mosi_q;
    logic        spck_rise, spck_fall, ncs_rise, ncs_fall;
    logic        act_q, act_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] rb_q, rb_d;
    logic        miso_q, miso_d;
    logic        end_ok, end_bad, wr_conf, wr_div;
    logic [7:0]  new_v;
    state_e      state_q, state_d;
    logic [7:0]  conf_q, conf_d, pend_q, pend_d, div_q, div_d, guard_q, guard_d;
    logic        busy_q, strobe_q, err_q;

    // Reset asserts asynchronously, releases two pck0 edges later.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) rst_q <= 2'b00;
        else       rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    // ncs chain resets to 0 so a frame already under way at release is
    // ignored until the next genuine falling edge.
    always_ff @(posedge pck0 or negedge rst_n) begin
        if (!rst_n) begin
            spck_q <= 3'b000;
            ncs_q  <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            spck_q <= {spck_q[1:0], spck};
            ncs_q  <= {ncs_q[1:0], ncs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign spck_rise = spck_q[1] & ~spck_q[2];
    assign spck_fall = ~spck_q[1] & spck_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];

    always_comb begin
        act_d   = act_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        rb_d    = rb_q;
        if (ncs_fall) begin
            act_d   = 1'b1;
            shift_d = 16'h0000;
            cnt_d   = 5'd0;
            rb_d    = {4'b1001, 3'b000, busy_q, conf_q};
        end else if (act_q && ncs_rise) begin
            act_d = 1'b0;
        end else if (act_q) begin
            if (spck_rise) begin
                shift_d = {shift_q[14:0], mosi_q[1]};
                cnt_d   = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
            end
            if (spck_fall) rb_d = {rb_q[14:0], 1'b0};
        end
        miso_d = act_d ? rb_d[15] : 1'b0;
    end

    assign end_ok  = act_q & ncs_rise & (cnt_q == 5'd16);
    assign end_bad = act_q & ncs_rise & (cnt_q != 5'd16);
    assign wr_conf = end_ok & (shift_q[15:12] == 4'b0001);
    assign wr_div  = end_ok & (shift_q[15:12] == 4'b0010);
    assign new_v   = shift_q[7:0];

    always_ff @(posedge pck0 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Mode 111 is already "everything off", so it never needs a guard interval.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (wr_conf && new_v[7:5] != conf_q[7:5] && new_v[7:5] != 3'b111) ? QUIESCE : IDLE;
        else if (wr_conf)
            state_d = (new_v[7:5] == 3'b111) ? IDLE : QUIESCE;
        else
            state_d = (guard_q == 8'd0) ? IDLE : QUIESCE;
    end

    // A conf write during QUIESCE takes priority over guard expiry.
    always_comb begin
        conf_d  = conf_q;
        pend_d  = pend_q;
        guard_d = guard_q;
        div_d   = wr_div ? new_v : div_q;
        if (state_q == IDLE) begin
            if (wr_conf && state_d == QUIESCE) begin
                pend_d  = new_v;
                conf_d  = OFF_CONF;
                guard_d = GUARD_LD;
            end else if (wr_conf) begin
                conf_d = new_v;
            end
        end else if (wr_conf) begin
            pend_d  = new_v;
            guard_d = GUARD_LD;
            conf_d  = (state_d == IDLE) ? new_v : conf_q;
        end else if (guard_q == 8'd0) begin
            conf_d = pend_q;
        end else begin
            guard_d = guard_q - 8'd1;
        end
    end

    always_ff @(posedge pck0 or negedge rst_n) begin
        if (!rst_n) begin
            act_q    <= 1'b0;
            shift_q  <= 16'h0000;
            cnt_q    <= 5'd0;
            rb_q     <= 16'h0000;
            miso_q   <= 1'b0;
            conf_q   <= OFF_CONF;
            pend_q   <= 8'h00;
            div_q    <= DIV_RESET;
            guard_q  <= 8'd0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            act_q    <= act_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            rb_q     <= rb_d;
            miso_q   <= miso_d;
            conf_q   <= conf_d;
            pend_q   <= pend_d;
            div_q    <= div_d;
            guard_q  <= guard_d;
            busy_q   <= (state_d == QUIESCE);
            strobe_q <= end_ok;
            err_q    <= end_bad;
        end
    end

    assign miso       = miso_q;
    assign conf_word  = conf_q;
    assign divisor    = div_q;
    assign busy       = busy_q;
    assign cmd_strobe = strobe_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_fpga_conf_ctrl.sv
// tb_fpga_conf_ctrl: scoreboard bench for fpga_conf_ctrl with a timeline reference model
module tb_fpga_conf_ctrl;
    localparam int         G  = 200;
    localparam logic [7:0] DR = 8'd95;

    logic       pck0 = 1'b0, nrst = 1'b0, spck = 1'b0, ncs = 1'b1, mosi = 1'b0;
    logic       miso, busy, cmd_strobe, frame_err;
    logic [7:0] conf_word, divisor;

    fpga_conf_ctrl #(.GUARD_CYCLES(G), .DIV_RESET(DR)) dut (
        .pck0(pck0), .nrst(nrst), .spck(spck), .ncs(ncs), .mosi(mosi),
        .miso(miso), .conf_word(conf_word), .divisor(divisor), .busy(busy),
        .cmd_strobe(cmd_strobe), .frame_err(frame_err)
    );

    always #5 pck0 = ~pck0;

    int cyc = 0;
    always @(posedge pck0) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        bit          err;
        logic [15:0] data;
        int          rise;
    } item_t;
    item_t q[$];
    item_t it;

    logic [7:0] m_conf = 8'hE0, m_div = DR, m_pend = 8'h00;
    bit         m_busy = 1'b0;
    int         m_dl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pck0);
        #1;
    endtask

    task automatic apply(input logic [15:0] d);
        logic [7:0] nv;
        nv = d[7:0];
        if (d[15:12] == 4'h2) m_div = nv;
        if (d[15:12] == 4'h1) begin
            if (nv[7:5] == 3'b111) begin
                m_conf = nv;
                m_busy = 1'b0;
            end else if (!m_busy && nv[7:5] == m_conf[7:5]) begin
                m_conf = nv;
            end else begin
                m_pend = nv;
                m_conf = 8'hE0;
                m_busy = 1'b1;
                m_dl   = cyc + G;
            end
        end
    endtask

    always @(negedge pck0) begin
        if (!nrst) begin
            m_conf = 8'hE0;
            m_div  = DR;
            m_busy = 1'b0;
            q.delete();
        end else begin
            if (cmd_strobe || frame_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, cmd_strobe, frame_err}, 32'd0);
                end else begin
                    it = q.pop_front();
                    chk("strobe_latency", cyc, it.rise + 3);
                    chk("strobe_kind", {30'd0, cmd_strobe, frame_err}, it.err ? 32'd1 : 32'd2);
                    if (!it.err) apply(it.data);
                end
            end else if (q.size() > 0 && cyc > q[0].rise + 3) begin
                chk("strobe_timeout", cyc, q[0].rise + 3);
                void'(q.pop_front());
            end
            if (m_busy && cyc == m_dl) begin
                m_conf = m_pend;
                m_busy = 1'b0;
            end
            chk("conf_word", conf_word, m_conf);
            chk("divisor", divisor, m_div);
            chk("busy", busy, m_busy);
        end
    end

    task automatic send(input logic [16:0] bits, input int n, input bit chk_miso);
        logic [15:0] rbw;
        bit          ck;
        item_t       e;
        ck  = chk_miso && !m_busy;
        rbw = {4'b1001, 3'b000, m_busy, m_conf};
        ncs = 1'b0;
        wait_cyc(5);
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            wait_cyc(5);
            if (ck && i < 16) chk("miso_bit", miso, rbw[15-i]);
            spck = 1'b1;
            wait_cyc(5);
            spck = 1'b0;
        end
        wait_cyc(5);
        ncs    = 1'b1;
        e.err  = (n != 16);
        e.data = bits[15:0];
        e.rise = cyc;
        q.push_back(e);
        wait_cyc(8);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_conf"}, conf_word, 8'hE0);
        chk({tag, "_div"}, divisor, DR);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_miso"}, miso, 1'b0);
        chk({tag, "_strobes"}, {cmd_strobe, frame_err}, 2'b00);
    endtask

    initial begin
        logic [3:0]  hi;
        logic [16:0] d;
        int          n;
        wait_cyc(3);
        check_reset_vals("in_reset");
        nrst = 1'b1;
        wait_cyc(5);
        check_reset_vals("after_reset");

        send(17'h02060, 16, 1);
        send(17'h01040, 16, 1);
        wait_cyc(G + 10);
        send(17'h01041, 16, 1);
        send(17'h01080, 16, 0);
        send(17'h010A3, 16, 0);
        wait_cyc(G + 10);
        send(17'h01080, 16, 0);
        send(17'h010E0, 16, 0);
        wait_cyc(20);
        send(17'h1ABCD, 17, 0);
        send(17'h02011, 15, 0);
        send(17'h05A5A, 16, 1);
        send(17'h01041, 16, 0);
        wait_cyc(G + 10);
        send(17'h03000, 16, 1);
        chk("miso_idle", miso, 1'b0);

        send(17'h01080, 16, 0);
        wait_cyc(20);
        @(posedge pck0);
        #3 nrst = 1'b0;
        #1 check_reset_vals("async_reset");
        wait_cyc(4);
        nrst = 1'b1;
        wait_cyc(6);
        check_reset_vals("post_quiesce_reset");

        ncs = 1'b0;
        wait_cyc(5);
        for (int i = 0; i < 6; i++) begin
            mosi = i[0];
            spck = 1'b1;
            wait_cyc(5);
            spck = 1'b0;
            wait_cyc(5);
        end
        nrst = 1'b0;
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(5);
        for (int i = 0; i < 10; i++) begin
            spck = 1'b1;
            wait_cyc(5);
            spck = 1'b0;
            wait_cyc(5);
        end
        ncs = 1'b1;
        wait_cyc(10);
        check_reset_vals("partial_frame");
        send(17'h02033, 16, 1);
        send(17'h010E5, 16, 1);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    hi = 4'h1;
                2:       hi = 4'h2;
                default: hi = 4'($urandom_range(3, 15));
            endcase
            d = {1'b0, hi, 4'($urandom), 8'($urandom)};
            n = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
            if (n == 17) d = {d[15:0], 1'b1};
            if (n == 15) d = {2'b00, d[15:1]};
            send(d, n, 1);
            wait_cyc($urandom_range(0, G));
        end

        wait_cyc(G + 20);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fpga_conf_ctrl.md
# fpga_conf_ctrl

- Replaces the raw `posedge ncs` configuration latch with a synchronous configuration controller, clocked on `pck0`.
- Receives 16-bit SPI command frames from the ARM, decodes conf and divisor writes, and applies them without glitching the coil drivers.
- When the major mode changes, it holds the FPGA in mode 111 (everything off) for a guard interval, then applies the new configuration.
- Its `conf_word`/`divisor` outputs feed the major-mode decode and mux8 output muxes in `fpga`.

## Interface
- `GUARD_CYCLES`, default 64: number of `pck0` cycles spent in mode 111 on a major-mode change; legal range 1..255.
- `DIV_RESET`, default 8'd95: `divisor` value after reset.
- `pck0`  in  1  sole clock; all state is on its rising edge.
- `nrst`  in  1  reset, asynchronous, active-low; internal deassertion synchronized to `pck0`.
- `spck`  in  1  SPI clock from ARM, asynchronous; high and low times must each be ≥4 `pck0` periods.
- `ncs`  in  1  SPI chip select, active-low, asynchronous.
- `mosi`  in  1  SPI data, sampled on `spck` rising edge.
- `miso`  out  1  SPI readback data.
- `conf_word`  out  8  active configuration; [7:5] is the major mode.
- `divisor`  out  8  active LF clock divisor.
- `busy`  out  1  high while a major-mode switch is in progress.
- `cmd_strobe`  out  1  one-cycle pulse when a valid frame is decoded.
- `frame_err`  out  1  one-cycle pulse when a frame with a bit count other than 16 ends.

## Operation
- **Synchronizers.** `spck`, `ncs` and `mosi` each pass through a 2-flop synchronizer; a third flop on `spck` and `ncs` provides edge detection. All frame logic uses these synchronized edges only.
- **Frame start** (`ncs` falling edge):
  - clear the 16-bit shift register and the bit counter;
  - load the readback register with {4'b1001, 3'b000, `busy`, `conf_word`}.
- **Bit capture.** On each `spck` rising edge while `ncs` is low:
  - shift the synchronized `mosi` into bit 0; data is MSB first;
  - the 5-bit bit counter saturates at 17.
- **Readback.** `miso` = readback[15] while `ncs` is low, otherwise 0. Readback shifts left on each `spck` falling edge while `ncs` is low.
- **Frame end** (`ncs` rising edge):
  - if the count is not 16: pulse `frame_err` and change no other state;
  - otherwise pulse `cmd_strobe` and decode shift[15:12]:
    - 4'b0001: conf write of shift[7:0];
    - 4'b0010: `divisor` ← shift[7:0] on the next cycle;
    - any other value: no effect, but `cmd_strobe` still pulses.
- **FSM states:** IDLE, QUIESCE.
- **Conf write handling:**
  - IDLE, new major equal to the current major, or new major = 111: `conf_word` ← new value next cycle; stay in IDLE.
  - IDLE, different major: `pending` ← new value; `conf_word` ← 8'hE0; load the guard counter with GUARD_CYCLES−1; `busy`=1; go to QUIESCE.
  - QUIESCE, any conf write: `pending` is overwritten and the guard counter reloads. If the new major is 111, apply it immediately and return to IDLE. `conf_word` stays 8'hE0 otherwise.
  - QUIESCE, counter = 0: `conf_word` ← `pending`; `busy`=0; go to IDLE.
- **Divisor writes** never wait on the FSM.
- **Asserting `nrst`**, including mid-frame or mid-QUIESCE, immediately:
  - sets `conf_word`=8'hE0, `divisor`=DIV_RESET, `miso`=0, `busy`=0, `cmd_strobe`=0, `frame_err`=0;
  - sets the FSM to IDLE and clears the shift register, counter and `pending`;
  - any partial frame is discarded.
- A frame in progress when reset releases (`ncs` already low) is counted from the next `ncs` falling edge only. Its `ncs` rising edge raises neither `cmd_strobe` nor `frame_err`.

## Timing
- Input synchronization latency: 3 `pck0` cycles from pin edge to detected edge.
- Let T be the cycle in which the `ncs` rising edge is detected. At T+1, `cmd_strobe`/`frame_err` are high for exactly one cycle, and `divisor` or a same-major `conf_word` update is visible.
- Major change:
  - `conf_word`=8'hE0 and `busy`=1 from T+1;
  - the new `conf_word` appears and `busy` falls at T+1+GUARD_CYCLES;
  - mode 111 is therefore held for exactly GUARD_CYCLES cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- `miso` changes ≤4 `pck0` cycles after the `spck` falling edge, so it is valid before the next `spck` rising edge given the ≥4-cycle high/low constraint.

## Test plan
- Reset: release `nrst` → `conf_word`=8'hE0, `divisor`=95, `busy`=0, `miso`=0; no strobes.
- Frame 16'h2060 → `cmd_strobe` pulses; `divisor`=8'h60 at T+1; `conf_word` unchanged.
- From IDLE with conf 8'h40, send 16'h1041 → `conf_word`=8'h41 at T+1 (same major, no quiesce). Then send 16'h1080 → `busy`=1 and `conf_word`=8'hE0 for 64 cycles, then `conf_word`=8'h80 and `busy`=0.
- During QUIESCE, send 16'h10A3 → guard restarts; `conf_word`=8'hA3 64 cycles after the second frame's T+1. Send 16'h10E0 during QUIESCE → immediate apply; `busy`=0 next cycle.
- Frames of 15 and 17 bits → `frame_err` pulses; `conf_word` and `divisor` unchanged; `cmd_strobe` stays low.
- Readback with `conf_word`=8'h41 in IDLE → `miso` sequence 1001_0000_0100_0001. Assert `nrst` mid-QUIESCE → outputs return to reset values immediately, and a following valid frame decodes normally.
